// File: rtl/hex_dump_seq.sv
// hex_dump_seq
// Converts one DATA_W-bit word into its uppercase ASCII hexadecimal text,
// most significant nibble first, and streams the characters to a UART
// transmitter over a valid/ready handshake. Optionally a CR LF pair follows
// the last digit.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   in_data   in   DATA_W  word to convert
//   in_valid  in   1       in_data is valid
//   in_ready  out  1       block is idle and accepts a word
//   tx_data   out  8       ASCII character (registered)
//   tx_valid  out  1       tx_data is valid (registered)
//   tx_ready  in   1       transmitter accepts tx_data
//   busy      out  1       a word is being emitted
module hex_dump_seq #(
    parameter int DATA_W    = 32,
    parameter int SEND_CRLF = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam bit   USE_CRLF = (SEND_CRLF != 0);
    localparam logic [7:0] CHR_CR  = 8'h0D;
    localparam logic [7:0] CHR_LF  = 8'h0A;
    localparam logic [7:0] CHR_NUL = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } state_t;

    // ASCII code of one hex nibble, uppercase letters.
    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        logic [7:0] chr;
        if (nib < 4'd10) begin
            chr = 8'h30 + {4'h0, nib};
        end else begin
            chr = 8'h37 + {4'h0, nib};
        end
        return chr;
    endfunction

    // Nibble of the captured word selected by a nibble index.
    function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] word,
                                          input logic [IDX_W-1:0]  idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

    state_t              r_state;
    logic [DATA_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_word_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [7:0]          w_tx_data_nxt;
    logic                w_tx_valid_nxt;
    logic                w_xfer;
    logic [IDX_W-1:0]    w_idx_dec;

    assign w_xfer    = r_tx_valid & tx_ready;
    assign w_idx_dec = r_idx - IDX_W'(1);

    // Next-state and next-output logic; the character for the next cycle is
    // computed here so that tx_data/tx_valid come straight from flops.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_nxt     = r_word;
        w_idx_nxt      = r_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_word_nxt     = in_data;
                    w_idx_nxt      = IDX_LAST;
                    w_tx_data_nxt  = nib_to_ascii(in_data[DATA_W-1 -: 4]);
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = ST_DIGIT;
                end else begin
                    w_tx_valid_nxt = 1'b0;
                end
            end
            ST_DIGIT: begin
                if (w_xfer) begin
                    if (r_idx != IDX_ZERO) begin
                        w_idx_nxt     = w_idx_dec;
                        w_tx_data_nxt = nib_to_ascii(nib_at(r_word, w_idx_dec));
                    end else if (USE_CRLF) begin
                        w_tx_data_nxt = CHR_CR;
                        w_state_nxt   = ST_CR;
                    end else begin
                        w_tx_data_nxt  = CHR_NUL;
                        w_tx_valid_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_DIGIT;
                end
            end
            ST_CR: begin
                if (w_xfer) begin
                    w_tx_data_nxt = CHR_LF;
                    w_state_nxt   = ST_LF;
                end else begin
                    w_state_nxt = ST_CR;
                end
            end
            ST_LF: begin
                if (w_xfer) begin
                    w_tx_data_nxt  = CHR_NUL;
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LF;
                end
            end
            default: begin
                w_tx_data_nxt  = CHR_NUL;
                w_tx_valid_nxt = 1'b0;
                w_idx_nxt      = IDX_ZERO;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // State, captured word, nibble index and output character registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_word     <= {DATA_W{1'b0}};
            r_idx      <= IDX_ZERO;
            r_tx_data  <= CHR_NUL;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hex_dump_seq.sv
// Directed bench for hex_dump_seq: a 32-bit instance with CR/LF and an
// 8-bit instance without, sharing clock, reset and tx_ready.
module tb_hex_dump_seq;

    logic        clk;
    logic        rst_n;
    logic        tx_ready;

    logic [31:0] in_data32;
    logic        in_valid32;
    logic        in_ready32;
    logic [7:0]  tx_data32;
    logic        tx_valid32;
    logic        busy32;

    logic [7:0]  in_data8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  tx_data8;
    logic        tx_valid8;
    logic        busy8;

    hex_dump_seq #(.DATA_W(32), .SEND_CRLF(1)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data32),
        .in_valid (in_valid32),
        .in_ready (in_ready32),
        .tx_data  (tx_data32),
        .tx_valid (tx_valid32),
        .tx_ready (tx_ready),
        .busy     (busy32)
    );

    hex_dump_seq #(.DATA_W(8), .SEND_CRLF(0)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data8),
        .in_valid (in_valid8),
        .in_ready (in_ready8),
        .tx_data  (tx_data8),
        .tx_valid (tx_valid8),
        .tx_ready (tx_ready),
        .busy     (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs of whichever instance the current vector targets.
    logic       g_sel;
    logic [7:0] c_tx_data;
    logic       c_tx_valid;
    logic       c_in_ready;
    logic       c_busy;
    assign c_tx_data  = g_sel ? tx_data8   : tx_data32;
    assign c_tx_valid = g_sel ? tx_valid8  : tx_valid32;
    assign c_in_ready = g_sel ? in_ready8  : in_ready32;
    assign c_busy     = g_sel ? busy8      : busy32;

    typedef struct packed {
        logic        sel;       // 0: 32-bit/CRLF instance, 1: 8-bit instance
        logic        intr;      // pulse a second word while busy
        logic [31:0] data;
        logic [3:0]  n;         // characters expected
        logic [3:0]  stall_at;  // character index to stall before (15 = none)
        logic [3:0]  stall_cyc;
        logic [79:0] chars;     // expected characters, first in bits 79:72
    } vec_t;

    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic sel, input logic v);
        if (sel) begin
            in_valid8 = v;
        end else begin
            in_valid32 = v;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int cyc;
        int stall_left;
        logic [7:0] exp_c;
        g_sel = v.sel;
        #0;
        cyc = 0;
        while (!c_in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk("accept_ready", {31'd0, c_in_ready}, 32'd1);
        if (v.sel) begin
            in_data8 = v.data[7:0];
        end else begin
            in_data32 = v.data;
        end
        set_valid(v.sel, 1'b1);
        tx_ready = 1'b1;
        step();
        set_valid(v.sel, 1'b0);
        k = 0;
        cyc = 0;
        stall_left = int'(v.stall_cyc);
        while (k < int'(v.n) && cyc < 100) begin
            exp_c = v.chars[79 - 8*k -: 8];
            if (v.intr && k >= 2 && k < 4) begin
                in_data32  = 32'h12345678;
                in_valid32 = 1'b1;
            end else begin
                set_valid(v.sel, 1'b0);
            end
            chk("busy_mid", {31'd0, c_busy}, 32'd1);
            chk("tx_valid", {31'd0, c_tx_valid}, 32'd1);
            if (k == int'(v.stall_at) && stall_left > 0) begin
                tx_ready = 1'b0;
                chk("hold_data", {24'd0, c_tx_data}, {24'd0, exp_c});
                stall_left--;
            end else begin
                tx_ready = 1'b1;
                chk("char", {24'd0, c_tx_data}, {24'd0, exp_c});
                k++;
            end
            step();
            cyc++;
        end
        if (cyc >= 100) begin
            chk("timeout", 32'd1, 32'd0);
        end
        set_valid(v.sel, 1'b0);
        tx_ready = 1'b1;
        chk("end_ready", {31'd0, c_in_ready}, 32'd1);
        chk("end_busy", {31'd0, c_busy}, 32'd0);
        chk("end_valid", {31'd0, c_tx_valid}, 32'd0);
        step();
        chk("stay_busy", {31'd0, c_busy}, 32'd0);
        chk("stay_valid", {31'd0, c_tx_valid}, 32'd0);
    endtask

    vec_t tbl [6];
    vec_t hv;

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        g_sel      = 1'b0;
        rst_n      = 1'b0;
        tx_ready   = 1'b0;
        in_valid32 = 1'b0;
        in_data32  = 32'd0;
        in_valid8  = 1'b0;
        in_data8   = 8'd0;

        tbl[0] = '{sel:1'b0, intr:1'b0, data:32'hDEADBEEF, n:4'd10, stall_at:4'd15, stall_cyc:4'd0,
                   chars:80'h44454144424545460D0A};
        tbl[1] = '{sel:1'b0, intr:1'b0, data:32'h0000000A, n:4'd10, stall_at:4'd1, stall_cyc:4'd3,
                   chars:80'h30303030303030410D0A};
        tbl[2] = '{sel:1'b0, intr:1'b1, data:32'hCAFEF00D, n:4'd10, stall_at:4'd15, stall_cyc:4'd0,
                   chars:80'h43414645463030440D0A};
        tbl[3] = '{sel:1'b0, intr:1'b0, data:32'h01234567, n:4'd10, stall_at:4'd15, stall_cyc:4'd0,
                   chars:80'h30313233343536370D0A};
        tbl[4] = '{sel:1'b0, intr:1'b0, data:32'h89ABCDEF, n:4'd10, stall_at:4'd9, stall_cyc:4'd2,
                   chars:80'h38394142434445460D0A};
        tbl[5] = '{sel:1'b1, intr:1'b0, data:32'h0000003F, n:4'd2, stall_at:4'd15, stall_cyc:4'd0,
                   chars:80'h33460000000000000000};

        // Reset values while rst_n is low.
        #3;
        chk("rst_valid32", {31'd0, tx_valid32}, 32'd0);
        chk("rst_data32", {24'd0, tx_data32}, 32'd0);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
        chk("rst_ready32", {31'd0, in_ready32}, 32'd1);
        chk("rst_valid8", {31'd0, tx_valid8}, 32'd0);
        chk("rst_ready8", {31'd0, in_ready8}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i]);
        end

        // Reset mid-word after three digits of 0x89ABCDEF.
        g_sel      = 1'b0;
        tx_ready   = 1'b1;
        in_data32  = 32'h89ABCDEF;
        in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0;
        chk("pre_rst_c0", {24'd0, tx_data32}, 32'h38);
        step();
        chk("pre_rst_c1", {24'd0, tx_data32}, 32'h39);
        step();
        chk("pre_rst_c2", {24'd0, tx_data32}, 32'h41);
        step();
        chk("pre_rst_c3", {24'd0, tx_data32}, 32'h42);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, tx_valid32}, 32'd0);
        chk("async_busy", {31'd0, busy32}, 32'd0);
        chk("async_ready", {31'd0, in_ready32}, 32'd1);
        chk("async_data", {24'd0, tx_data32}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_quiet", {31'd0, tx_valid32}, 32'd0);
            step();
        end
        hv = '{sel:1'b0, intr:1'b0, data:32'h00000001, n:4'd10, stall_at:4'd15, stall_cyc:4'd0,
               chars:80'h30303030303030310D0A};
        run_vec(hv);

        // Back-to-back words with in_valid held high.
        g_sel      = 1'b0;
        tx_ready   = 1'b1;
        in_data32  = 32'hFFFFFFFF;
        in_valid32 = 1'b1;
        step();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 10; k++) begin
                chk("b2b_valid", {31'd0, tx_valid32}, 32'd1);
                chk("b2b_char", {24'd0, tx_data32},
                    (k < 8) ? 32'h46 : ((k == 8) ? 32'h0D : 32'h0A));
                step();
            end
            chk("b2b_gap_ready", {31'd0, in_ready32}, 32'd1);
            chk("b2b_gap_valid", {31'd0, tx_valid32}, 32'd0);
            if (w == 1) begin
                in_valid32 = 1'b0;
            end
            step();
        end
        chk("b2b_done_busy", {31'd0, busy32}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_dump_seq.md
HEX_DUMP_SEQ -- requirements
Module: hex_dump_seq

Interface
REQ-001 Parameter DATA_W, default 32, width of the word to be dumped; SHALL be a multiple of 4 and at least 4; NIB = DATA_W/4.
REQ-002 Parameter SEND_CRLF, default 1, appends CR (0x0D) then LF (0x0A) after the last digit when 1.
REQ-003 The block SHALL have the following ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  DATA_W  word to convert.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word.
- tx_data  output  8  ASCII character to the UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART transmitter accepts tx_data.
- busy  output  1  a word is being emitted.

Function
REQ-004 States SHALL be IDLE, DIGIT, CR and LF; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, in_ready SHALL be 1 and tx_valid SHALL be 0; in_ready SHALL be 0 in all other states.
REQ-006 On a rising edge with in_valid=1 and in_ready=1, the block SHALL perform the following in the same edge:
- capture in_data into an internal register;
- set the nibble index to NIB-1;
- enter DIGIT.
REQ-007 In DIGIT, tx_data SHALL be the ASCII code of the captured nibble at the current index, and tx_valid SHALL be 1.
- Values 0-9 map to 0x30-0x39.
- Values A-F map to 0x41-0x46 (uppercase).
- Digits are sent MSB nibble first.
REQ-008 tx_data and tx_valid SHALL be registered outputs.
- The first character appears on the cycle after the accept edge (1-cycle latency).
REQ-009 A character SHALL transfer only on an edge where tx_valid=1 and tx_ready=1.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL be held stable.
- tx_valid SHALL NOT be withdrawn without a transfer.
REQ-010 On a transfer in DIGIT with index greater than 0, the index SHALL decrement by 1 and the next digit SHALL be presented on the following cycle.
- With tx_ready held at 1, exactly one character transfers per cycle.
REQ-011 On a transfer in DIGIT with index 0, the next state SHALL be CR when SEND_CRLF=1, otherwise IDLE.
REQ-012 In CR, tx_data SHALL be 0x0D; a transfer SHALL move the block to LF.
REQ-013 In LF, tx_data SHALL be 0x0A; a transfer SHALL move the block to IDLE.
REQ-014 A new word SHALL be accepted no earlier than the edge after the final transfer.
- in_ready returns to 1 the cycle after the last character transfers.
- Acceptance and final transfer are never on the same edge.
REQ-015 in_valid and in_data SHALL be ignored while busy=1.
- The captured word SHALL NOT change until the block returns to IDLE.
REQ-016 tx_ready asserted while tx_valid=0 SHALL have no effect.
REQ-017 The nibble index width SHALL be ceil(log2(NIB)) bits, with a minimum of 1.
- The index SHALL never wrap below 0.
- Every word SHALL emit exactly NIB digits, plus 2 characters when SEND_CRLF=1.

Reset
REQ-018 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE with the following values:
- tx_valid=0, tx_data=0x00, busy=0, in_ready=1;
- index=0, captured word=0.
REQ-019 Reset asserted mid-word SHALL abort the word with no further characters.
- After rst_n deasserts, the block SHALL wait in IDLE for a new in_valid.
REQ-020 The first accept after reset deassertion SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-021 Bench SHALL cover the following directed scenarios:
- DATA_W=32, SEND_CRLF=1, in_data=0xDEADBEEF, tx_ready always 1 -> 10 consecutive transfers 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46,0x0D,0x0A; in_ready=1 on the cycle after the 0x0A transfer.
- in_data=0x0000000A, tx_ready=0 for 3 cycles while the 2nd digit is presented -> tx_data holds 0x30 with tx_valid=1 throughout; sequence resumes 0x30...0x41,0x0D,0x0A; no character dropped or duplicated.
- DATA_W=8, SEND_CRLF=0, in_data=0x3F -> transfers 0x33,0x46, then IDLE; no CR/LF.
- in_valid pulsed with in_data=0x12345678 while busy during a 0xCAFEF00D dump -> output is CAFEF00D+CRLF only; second word not captured.
- rst_n low for 1 cycle after 3 digits of 0x89ABCDEF -> tx_valid=0 and busy=0 immediately; no further characters; next word 0x00000001 dumps as 0x30 x7,0x31,0x0D,0x0A.
- in_valid held high continuously with 0xFFFFFFFF -> back-to-back words separated by exactly one IDLE cycle; each emits 0x46 x8,0x0D,0x0A.
